// File: rtl/adc_spi_responder.sv
// adc_spi_responder: slave model of the 8-ch 12-bit serial ADC behind adc_ctrl.
// Ports: iCLK/iRST, serial pins iCS/iSCLK/iDIN/oDOUT, iCH_DATA, oCFG/oCFG_VALID, oBUSY, oERR_CNT.
`timescale 1ns/1ps
module adc_spi_responder #(
  parameter int CONV_CYCLES = 80,
  parameter int SYNC_STAGES = 2
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iCS,
  input  logic        iSCLK,
  input  logic        iDIN,
  output logic        oDOUT,
  input  logic [95:0] iCH_DATA,
  output logic [5:0]  oCFG,
  output logic        oCFG_VALID,
  output logic        oBUSY,
  output logic [7:0]  oERR_CNT
);

  localparam int CW = $clog2(CONV_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE, SHIFT, CONV, SLEEP
  } state_e;

  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] din_sync_q;
  logic cs_prev_q, sclk_prev_q;

  state_e      state_q, state_d;
  logic [11:0] out_sr_q, out_sr_d;
  logic        dout_q, dout_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [5:0]  cfg_sr_q, cfg_sr_d;
  logic [5:0]  cfg_q, cfg_d;
  logic        cfg_valid_q, cfg_valid_d;
  logic [7:0]  err_q, err_d;
  logic [11:0] result_q, result_d;
  logic [11:0] sample_q, sample_d;
  logic        uni_q, uni_d;
  logic [CW-1:0] conv_cnt_q, conv_cnt_d;
  logic        armed_q, armed_d;

  logic cs_s, sclk_s, din_s;
  logic cs_fall, cs_rise, sclk_rise, sclk_fall;
  logic [11:0] ch_val;
  logic [7:0]  err_inc;

  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign din_s  = din_sync_q[SYNC_STAGES-1];

  assign cs_fall   = cs_prev_q & ~cs_s;
  assign cs_rise   = ~cs_prev_q & cs_s;
  assign sclk_rise = ~sclk_prev_q & sclk_s;
  assign sclk_fall = sclk_prev_q & ~sclk_s;

  assign err_inc = (err_q == 8'hFF) ? err_q : err_q + 8'd1;

  // Channel picked by {OS,S1,S0} of the word being accepted.
  always_comb begin
    ch_val = '0;
    for (int i = 0; i < 8; i++) begin
      if (cfg_sr_q[4:2] == 3'(i)) ch_val = iCH_DATA[12*i +: 12];
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      cs_sync_q   <= '0;
      sclk_sync_q <= '0;
      din_sync_q  <= '0;
      cs_prev_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
      state_q     <= IDLE;
      out_sr_q    <= '0;
      dout_q      <= 1'b0;
      bit_cnt_q   <= '0;
      cfg_sr_q    <= '0;
      cfg_q       <= '0;
      cfg_valid_q <= 1'b0;
      err_q       <= '0;
      result_q    <= '0;
      sample_q    <= '0;
      uni_q       <= 1'b0;
      conv_cnt_q  <= '0;
      armed_q     <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], iCS};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], iSCLK};
      din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], iDIN};
      cs_prev_q   <= cs_s;
      sclk_prev_q <= sclk_s;
      state_q     <= state_d;
      out_sr_q    <= out_sr_d;
      dout_q      <= dout_d;
      bit_cnt_q   <= bit_cnt_d;
      cfg_sr_q    <= cfg_sr_d;
      cfg_q       <= cfg_d;
      cfg_valid_q <= cfg_valid_d;
      err_q       <= err_d;
      result_q    <= result_d;
      sample_q    <= sample_d;
      uni_q       <= uni_d;
      conv_cnt_q  <= conv_cnt_d;
      armed_q     <= armed_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    out_sr_d    = out_sr_q;
    dout_d      = dout_q;
    bit_cnt_d   = bit_cnt_q;
    cfg_sr_d    = cfg_sr_q;
    cfg_d       = cfg_q;
    cfg_valid_d = 1'b0;
    err_d       = err_q;
    result_d    = result_q;
    sample_d    = sample_q;
    uni_d       = uni_q;
    conv_cnt_d  = conv_cnt_q;
    armed_d     = armed_q | cs_s;

    unique case (state_q)
      IDLE, SLEEP: begin
        // A CS low held through reset never opens a frame.
        if (cs_fall && armed_q) begin
          out_sr_d  = result_q;
          dout_d    = result_q[11];
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        // CS edge takes priority over a coincident SCLK edge.
        if (cs_rise) begin
          if (bit_cnt_q >= 4'd6) begin
            cfg_d       = cfg_sr_q;
            cfg_valid_d = 1'b1;
            if (cfg_sr_q[0]) begin
              state_d = SLEEP;
            end else begin
              sample_d   = ch_val;
              uni_d      = cfg_sr_q[1];
              conv_cnt_d = '0;
              state_d    = CONV;
            end
          end else begin
            err_d   = err_inc;
            state_d = IDLE;
          end
        end else if (sclk_rise) begin
          if (bit_cnt_q < 4'd6) cfg_sr_d = {cfg_sr_q[4:0], din_s};
          if (bit_cnt_q != 4'd12) bit_cnt_d = bit_cnt_q + 4'd1;
        end else if (sclk_fall) begin
          out_sr_d = {out_sr_q[10:0], 1'b0};
          dout_d   = out_sr_q[10];
        end
      end
      CONV: begin
        if (cs_fall) begin
          err_d     = err_inc;
          out_sr_d  = result_q;
          dout_d    = result_q[11];
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end else if (conv_cnt_q == CW'(CONV_CYCLES - 1)) begin
          // Bipolar mode returns offset binary as two's complement.
          result_d = uni_q ? sample_q : (sample_q ^ 12'h800);
          state_d  = IDLE;
        end else begin
          conv_cnt_d = conv_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign oDOUT      = dout_q;
  assign oCFG       = cfg_q;
  assign oCFG_VALID = cfg_valid_q;
  assign oBUSY      = (state_q == CONV);
  assign oERR_CNT   = err_q;

endmodule
